// File: rtl/pmod_cond_pkg.sv
// Shared constants and helpers for the PMOD input conditioner.
package pmod_cond_pkg;

  localparam int PMOD_W                = 8;
  localparam int PMOD_DEBOUNCE_DEFAULT = 12000;

  // Counter width able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pmod_input_cond_debounce_bit.sv
// One PMOD pin: two-flop synchronizer followed by a stability-counter debouncer.
// Raises evt for one cycle on the edge where the debounced level changes.
module debounce_bit
  import pmod_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PMOD_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic evt
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             ff1_q, ff1_d;
  logic             s_q, s_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_s;

  // The count only advances while the synchronized sample disagrees; it never passes CNT_LAST.
  always_comb begin
    ff1_d    = pin;
    s_d      = ff1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    evt_s    = 1'b0;
    if (s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s_q;
      cnt_d    = '0;
      evt_s    = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q    <= 1'b0;
      s_q      <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ff1_q    <= ff1_d;
      s_q      <= s_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign evt   = evt_s & ~rst;

endmodule

// File: rtl/pmod_input_cond.sv
// Debounced PMOD input byte for the I2C read-only registers.
// Define PMOD_COND_CHG_EN to add sticky per-bit change flags with a masked clear.
module pmod_input_cond
  import pmod_cond_pkg::*;
#(
  parameter int WIDTH           = PMOD_W,
  parameter int DEBOUNCE_CYCLES = PMOD_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pmod_in,
  output logic [WIDTH-1:0] pmod_out
`ifdef PMOD_COND_CHG_EN
  ,
  input  logic             clr_stb,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] pmod_chg,
  output logic             chg_any
`endif
);

  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] evt_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk   (clk),
      .rst   (rst),
      .pin   (pmod_in[i]),
      .level (level_s[i]),
      .evt   (evt_s[i])
    );
  end

  assign pmod_out = level_s;

`ifdef PMOD_COND_CHG_EN
  logic [WIDTH-1:0] chg_q, chg_d;

  // A new event beats a coincident clear so no transition is lost.
  always_comb begin
    chg_d = evt_s | (chg_q & ~(clr_mask & {WIDTH{clr_stb}}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign pmod_chg = chg_q;
  assign chg_any  = |chg_q;
`else
  logic unused_evt_s;
  assign unused_evt_s = ^evt_s;
`endif

endmodule

// File: tb/tb_pmod_input_cond.sv
// Scoreboard bench for pmod_input_cond with DEBOUNCE_CYCLES=4 and change flags enabled.
module tb_pmod_input_cond;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pmod_in;
  logic [7:0] pmod_out;
  logic       clr_stb;
  logic [7:0] clr_mask;
  logic [7:0] pmod_chg;
  logic       chg_any;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       chk;
    logic [7:0] o;
    logic [7:0] c;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  pmod_input_cond #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pmod_in  (pmod_in),
    .pmod_out (pmod_out)
`ifdef PMOD_COND_CHG_EN
    ,
    .clr_stb  (clr_stb),
    .clr_mask (clr_mask),
    .pmod_chg (pmod_chg),
    .chg_any  (chg_any)
`endif
  );

`ifndef PMOD_COND_CHG_EN
  assign pmod_chg = 8'h00;
  assign chg_any  = 1'b0;
`endif

  // Drive one cycle of inputs and queue what the outputs must be after that edge.
  task automatic step(input logic r, input logic [7:0] pin, input logic cs,
                      input logic [7:0] cm, input logic chk,
                      input logic [7:0] eo, input logic [7:0] ec, input string nm);
    exp_t e;
    rst      = r;
    pmod_in  = pin;
    clr_stb  = cs;
    clr_mask = cm;
    @(posedge clk);
    e.chk = chk;
    e.o   = eo;
    e.c   = ec;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.chk) begin
          n_checks++;
          if (pmod_out !== e.o) begin
            n_fail++;
            $display("FAIL %s pmod_out: got %h expected %h", nm, pmod_out, e.o);
          end
`ifdef PMOD_COND_CHG_EN
          n_checks++;
          if (pmod_chg !== e.c) begin
            n_fail++;
            $display("FAIL %s pmod_chg: got %h expected %h", nm, pmod_chg, e.c);
          end
          n_checks++;
          if (chg_any !== (|e.c)) begin
            n_fail++;
            $display("FAIL %s chg_any: got %b expected %b", nm, chg_any, |e.c);
          end
`endif
        end
      end
    end
  end

  initial begin
    logic [7:0] pin;
    logic [7:0] eo;
    logic [7:0] ec;

    // Reset with all pins high, then release: rise 6 edges later.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, "rst_hold");
    for (int i = 0; i < 5; i++) step(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, "rst_rel_wait");
    step(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF, "rst_rel_rise");
    step(1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'h00, "clr_all");
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, "fall_wait");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'hFF, "fall");
    step(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, "clr_all2");

    // 3-cycle glitch on bit 3 is rejected.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, "glitch3");
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, "glitch3_after");

    // 4-cycle pulse on bit 3 passes through for exactly 4 cycles.
    for (int i = 1; i <= 11; i++) begin
      pin = (i <= 4) ? 8'h08 : 8'h00;
      eo  = (i >= 6 && i <= 9) ? 8'h08 : 8'h00;
      ec  = (i >= 6) ? 8'h08 : 8'h00;
      step(1'b0, pin, 1'b0, 8'h00, 1'b1, eo, ec, "pulse4");
    end
    step(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, "clr_all3");

    // Bounce 1,1,1,0,1,1,1,1 on bit 0: one rise, 6 edges after the last run starts.
    for (int i = 1; i <= 12; i++) begin
      pin = (i == 4) ? 8'h00 : 8'h01;
      eo  = (i >= 10) ? 8'h01 : 8'h00;
      step(1'b0, pin, 1'b0, 8'h00, 1'b1, eo, eo, "bounce");
    end

    // Build pmod_chg=05, then masked clears.
    for (int i = 1; i <= 6; i++) begin
      eo = (i == 6) ? 8'h05 : 8'h01;
      step(1'b0, 8'h05, 1'b0, 8'h00, 1'b1, eo, eo, "set_05");
    end
    step(1'b0, 8'h05, 1'b0, 8'hFF, 1'b1, 8'h05, 8'h05, "mask_no_stb");
    step(1'b0, 8'h05, 1'b1, 8'h01, 1'b1, 8'h05, 8'h04, "clr_mask01");
    step(1'b0, 8'h05, 1'b1, 8'h04, 1'b1, 8'h05, 8'h00, "clr_mask04");

    // Clear of bit 1 coincides with its debounced rise: set wins.
    for (int i = 1; i <= 5; i++) step(1'b0, 8'h07, 1'b0, 8'h00, 1'b1, 8'h05, 8'h00, "collide_wait");
    step(1'b0, 8'h07, 1'b1, 8'h02, 1'b1, 8'h07, 8'h02, "collide");
    step(1'b0, 8'h07, 1'b1, 8'h02, 1'b1, 8'h07, 8'h00, "hold_clr");
    step(1'b0, 8'h07, 1'b1, 8'h02, 1'b1, 8'h07, 8'h00, "hold_clr2");

    // Reset in the middle of bit 7's count discards it.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h87, 1'b0, 8'h00, 1'b1, 8'h07, 8'h00, "mid_count");
    step(1'b1, 8'h87, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, "mid_rst");
    for (int i = 0; i < 5; i++) step(1'b0, 8'h87, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, "post_rst_wait");
    step(1'b0, 8'h87, 1'b0, 8'h00, 1'b1, 8'h87, 8'h87, "post_rst_rise");
    step(1'b0, 8'h87, 1'b0, 8'h00, 1'b1, 8'h87, 8'h87, "post_rst_hold");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
